onets_led_ctrl: RTL
===================

# onets_led_ctrl

Parametrised multi-channel status-indicator driver for the OneTSwitch PL fabric, the successor to the fixed free-running counter heartbeats that drive `pl_led`/`pl_pmod`. It runs on a single fabric clock, derives a shared tick from a programmable prescaler, and gives each of `NUM_CH` outputs a runtime-selectable mode:

- off
- on
- synchronous blink
- stretched activity flash with a guaranteed visible off gap

It sits between the RGMII/switch status sources (link, per-port rx/tx activity) and the board LED/PMOD pins.

## Interface
Parameters:
- `NUM_CH`, 4: number of independent output channels (1..32).
- `PRESCALE`, 12500000: clock cycles per tick (>=2). At 125 MHz this gives 100 ms.
- `BLINK_TICKS`, 5: ticks per blink half-period (>=1).
- `HOLD_TICKS`, 1: ticks per activity on-phase and per off-gap (>=1).
- `ACTIVE_LOW`, 0: 1 inverts all `led_o` bits at the output register.

Ports:
- `clk`, in, 1: fabric clock (`bd_fclk0_125m` in the top level). One clock; no other clock domains.
- `rst`, in, 1: reset, synchronous and active-high.
- `mode_i`, in, 2*NUM_CH: per-channel mode, bits [2c+1:2c]. Encodings: 00 OFF, 01 ON, 10 BLINK, 11 ACT.
- `act_i`, in, NUM_CH: per-channel activity strobe. Sampled every cycle, already in `clk` domain, may be held high.
- `led_o`, out, NUM_CH: registered indicator outputs.
- `tick_o`, out, 1: registered one-cycle prescaler tick, for daisy-chaining other status logic.

## Operation
- Prescaler:
  - `pcnt` counts 0..PRESCALE-1 and wraps.
  - Internal `tick` is high in the cycle where `pcnt==PRESCALE-1`.
  - `tick_o` is `tick` registered, one cycle later.
- Blink generator:
  - Global `bcnt` counts ticks 0..BLINK_TICKS-1.
  - On a tick with `bcnt==BLINK_TICKS-1`, `bcnt` returns to 0 and `blink_ph` toggles.
  - All BLINK channels therefore flash in phase.
- Per-channel logical LED value `lv`:
  - OFF: 0.
  - ON: 1.
  - BLINK: `blink_ph`.
  - ACT: 1 in FSM state ON, otherwise 0.
- `led_o[c] <= lv[c] ^ ACTIVE_LOW`.
- Activity FSM, per channel. States IDLE, ON, GAP; tick counter `hcnt`; flag `pend`.
  - IDLE: `act_i` high -> ON, `hcnt`=0.
  - ON: on each tick, `hcnt`++. On a tick with `hcnt==HOLD_TICKS-1` -> GAP, `hcnt`=0. Any `act_i` high while in ON or GAP sets `pend`.
  - GAP: on a tick with `hcnt==HOLD_TICKS-1`:
    - `pend` set (including `act_i` high in that same cycle) -> ON, `hcnt`=0, `pend` cleared.
    - otherwise -> IDLE.
  - Held-high `act_i` therefore produces continuous ON/GAP flashing. It never produces a solid-on output.
  - The FSM is active only in ACT mode. In any other mode it is forced to IDLE with `hcnt`=0 and `pend`=0.
- Mode change:
  - A new `mode_i` value takes effect on `led_o` at the next clock edge.
  - Leaving ACT discards any flash in progress.
  - Entering ACT starts in IDLE.
  - The prescaler and blink generator are never reset by mode changes.

## Timing
- Reset values:
  - `led_o` = {NUM_CH{ACTIVE_LOW}}.
  - `tick_o`=0.
  - `pcnt`=0, `bcnt`=0, `blink_ph`=0.
  - All FSMs IDLE, `hcnt`=0, `pend`=0.
- First `tick` falls in the PRESCALE-th cycle after reset deasserts. `tick_o` follows one cycle later.
- Latency:
  - ACT pulse in cycle t (FSM IDLE) -> `led_o` active at t+1.
  - OFF/ON/BLINK changes -> `led_o` updates at t+1.
- ACT on-time: between (HOLD_TICKS-1)*PRESCALE+1 and HOLD_TICKS*PRESCALE cycles. The gap obeys the same bounds.
- BLINK half-period: exactly BLINK_TICKS*PRESCALE cycles after the first toggle.
- `rst` asserted mid-flash or mid-blink: all state returns to reset values on that edge, and `pend` is lost.
- Widths:
  - `pcnt` is $clog2(PRESCALE) bits.
  - `bcnt` and `hcnt` are $clog2(max(BLINK_TICKS, HOLD_TICKS, 2)) bits.
  - No counter exceeds its terminal value.

## Test plan
Bench parameters: NUM_CH=4, PRESCALE=4, BLINK_TICKS=2, HOLD_TICKS=2, ACTIVE_LOW=0, unless noted.

- **Reset and tick:** release `rst` at cycle 0, all modes OFF -> `led_o`=0000; `tick_o` high at cycles 4, 8, 12, ….
- **Static and blink:** mode_i = {BLINK, BLINK, ON, OFF} -> `led_o[1]`=1 from cycle 1; `led_o[3:2]` toggle together every 8 cycles, rising at cycle 8; `led_o[0]`=0.
- **Single activity pulse:** ch0 in ACT, one-cycle `act_i[0]` at cycle 5 -> `led_o[0]` high cycles 6..11, low from cycle 12, IDLE after cycle 19.
- **Retrigger and hold-high:**
  - Second pulse during ON -> after the gap, a second flash starts at the gap-end tick.
  - `act_i[0]` held high for 100 cycles -> alternating on/off, never more than 8 consecutive high cycles.
- **Mode change and reset mid-flash:**
  - Switch ch0 ACT->OFF during ON -> `led_o[0]`=0 next cycle.
  - Back to ACT with no pulse -> stays 0.
  - `rst` during blink -> `led_o`=0000 next cycle, blink restarts from phase 0.
- **Polarity:** ACTIVE_LOW=1 -> reset `led_o`=1111; ON channel drives 0; single ACT pulse produces a 6-cycle low pulse.

Source files
------------

// File: rtl/onets_led_ctrl.sv
// Multi-channel status LED driver: shared prescaler tick, global blink phase,
// and a per-channel activity stretcher that always leaves a visible dark gap.
module onets_led_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int PRESCALE    = 12500000,
    parameter int BLINK_TICKS = 5,
    parameter int HOLD_TICKS  = 1,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*NUM_CH-1:0] mode_i,
    input  logic [NUM_CH-1:0]   act_i,
    output logic [NUM_CH-1:0]   led_o,
    output logic                tick_o
);
    localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CMAX = (BLINK_TICKS > HOLD_TICKS) ? BLINK_TICKS : HOLD_TICKS;
    localparam int CW   = $clog2((CMAX > 2) ? CMAX : 2);

    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] B_LAST = CW'(BLINK_TICKS - 1);
    localparam logic [CW-1:0] H_LAST = CW'(HOLD_TICKS - 1);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;

    // state | meaning: IDLE waiting for activity, ON flash lit, GAP forced dark
    typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

    logic [PW-1:0]     r_pcnt;
    logic              r_tick;
    logic [CW-1:0]     r_bcnt;
    logic              r_blink_ph;
    logic [NUM_CH-1:0] r_led;
    state_t            r_st [NUM_CH];
    logic [CW-1:0]     r_hcnt [NUM_CH];
    logic [NUM_CH-1:0] r_pend;

    logic              w_tick;
    logic [CW-1:0]     w_bcnt_nx;
    logic              w_blink_ph_nx;
    state_t            w_st_nx [NUM_CH];
    logic [CW-1:0]     w_hcnt_nx [NUM_CH];
    logic [NUM_CH-1:0] w_pend_nx;
    logic [NUM_CH-1:0] w_lv;

    assign w_tick = (r_pcnt == P_LAST);
    assign led_o  = r_led;
    assign tick_o = r_tick;

    always_comb begin
        w_bcnt_nx     = r_bcnt;
        w_blink_ph_nx = r_blink_ph;
        if (w_tick) begin
            if (r_bcnt == B_LAST) begin
                w_bcnt_nx     = '0;
                w_blink_ph_nx = ~r_blink_ph;
            end else begin
                w_bcnt_nx = r_bcnt + 1'b1;
            end
        end
    end

    // LED value is derived from next-state so mode and activity show one edge later
    always_comb begin
        w_pend_nx = r_pend;
        w_lv      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_st_nx[c]   = r_st[c];
            w_hcnt_nx[c] = r_hcnt[c];
            if (mode_i[2*c +: 2] != 2'b11) begin
                w_st_nx[c]   = S_IDLE;
                w_hcnt_nx[c] = '0;
                w_pend_nx[c] = 1'b0;
            end else begin
                case (r_st[c])
                    S_IDLE: begin
                        if (act_i[c]) begin
                            w_st_nx[c]   = S_ON;
                            w_hcnt_nx[c] = '0;
                        end
                    end
                    S_ON: begin
                        w_pend_nx[c] = r_pend[c] | act_i[c];
                        if (w_tick) begin
                            if (r_hcnt[c] == H_LAST) begin
                                w_st_nx[c]   = S_GAP;
                                w_hcnt_nx[c] = '0;
                            end else begin
                                w_hcnt_nx[c] = r_hcnt[c] + 1'b1;
                            end
                        end
                    end
                    S_GAP: begin
                        w_pend_nx[c] = r_pend[c] | act_i[c];
                        if (w_tick) begin
                            if (r_hcnt[c] == H_LAST) begin
                                w_hcnt_nx[c] = '0;
                                w_pend_nx[c] = 1'b0;
                                w_st_nx[c]   = (r_pend[c] | act_i[c]) ? S_ON : S_IDLE;
                            end else begin
                                w_hcnt_nx[c] = r_hcnt[c] + 1'b1;
                            end
                        end
                    end
                    default: w_st_nx[c] = S_IDLE;
                endcase
            end
            case (mode_i[2*c +: 2])
                MODE_OFF:   w_lv[c] = 1'b0;
                MODE_ON:    w_lv[c] = 1'b1;
                MODE_BLINK: w_lv[c] = w_blink_ph_nx;
                default:    w_lv[c] = (w_st_nx[c] == S_ON);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt     <= '0;
            r_tick     <= 1'b0;
            r_bcnt     <= '0;
            r_blink_ph <= 1'b0;
            r_led      <= {NUM_CH{ACTIVE_LOW}};
            r_pend     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_st[c]   <= S_IDLE;
                r_hcnt[c] <= '0;
            end
        end else begin
            r_pcnt     <= w_tick ? '0 : r_pcnt + 1'b1;
            r_tick     <= w_tick;
            r_bcnt     <= w_bcnt_nx;
            r_blink_ph <= w_blink_ph_nx;
            r_led      <= w_lv ^ {NUM_CH{ACTIVE_LOW}};
            r_pend     <= w_pend_nx;
            for (int c = 0; c < NUM_CH; c++) begin
                r_st[c]   <= w_st_nx[c];
                r_hcnt[c] <= w_hcnt_nx[c];
            end
        end
    end
endmodule
